// File: rtl/handshake_constant_seq.sv
// handshake_constant_seq
//   Elastic constant source: every accepted control token emits the next entry
//   of a compile-time table through a 2-entry output buffer, so ctrl_ready is a
//   register and never follows outs_ready combinationally.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   ctrl_valid  control token present
//   ctrl_ready  token can be accepted (registered)
//   idx_clear   one-cycle pulse returning the table index to 0
//   outs        constant at the buffer head
//   outs_idx    table index of the constant on outs
//   outs_valid  buffer non-empty
//   outs_ready  downstream accepts
module handshake_constant_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CONSTS = 4,
    parameter logic [NUM_CONSTS*DATA_WIDTH-1:0] CONST_VALUES = '0,
    parameter bit CYCLIC = 1'b1,
    parameter int unsigned IDX_W = $clog2((NUM_CONSTS > 1) ? NUM_CONSTS : 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    input  logic                  idx_clear,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_W-1:0]      outs_idx,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSTS - 1);

    // Table index and buffer: head register drives the outputs, tail queues behind it
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [DATA_WIDTH-1:0] head_val_q, head_val_d;
    logic [IDX_W-1:0]      head_idx_q, head_idx_d;
    logic [DATA_WIDTH-1:0] tail_val_q, tail_val_d;
    logic [IDX_W-1:0]      tail_idx_q, tail_idx_d;
    logic [1:0]            count_q,    count_d;
    logic                  ready_q,    ready_d;
    logic                  valid_q,    valid_d;

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] table_val;

    assign ctrl_ready = ready_q;
    assign outs_valid = valid_q;
    assign outs       = head_val_q;
    assign outs_idx   = head_idx_q;

    // Next-state: handshakes, buffer movement, index walk
    always_comb begin
        idx_d      = idx_q;
        head_val_d = head_val_q;
        head_idx_d = head_idx_q;
        tail_val_d = tail_val_q;
        tail_idx_d = tail_idx_q;
        count_d    = count_q;

        push      = ctrl_valid && ready_q;
        pop       = valid_q && outs_ready;
        table_val = CONST_VALUES[32'(idx_q) * DATA_WIDTH +: DATA_WIDTH];

        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_val_d = table_val;
                    head_idx_d = idx_q;
                end else begin
                    tail_val_d = table_val;
                    tail_idx_d = idx_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_val_d = tail_val_q;
                head_idx_d = tail_idx_q;
                count_d    = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with count==1: new entry replaces the popped head
                head_val_d = table_val;
                head_idx_d = idx_q;
            end
            default: ;
        endcase

        // Clear overrides the post-push increment; the push itself used the old idx
        if (idx_clear) begin
            idx_d = '0;
        end else if (push) begin
            if (idx_q < LAST_IDX) begin
                idx_d = idx_q + IDX_W'(1);
            end else begin
                idx_d = CYCLIC ? '0 : LAST_IDX;
            end
        end

        ready_d = (count_d < 2'd2);
        valid_d = (count_d != 2'd0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q      <= '0;
            head_val_q <= '0;
            head_idx_q <= '0;
            tail_val_q <= '0;
            tail_idx_q <= '0;
            count_q    <= 2'd0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            head_val_q <= head_val_d;
            head_idx_q <= head_idx_d;
            tail_val_q <= tail_val_d;
            tail_idx_q <= tail_idx_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Bench for handshake_constant_seq: a cyclic (dut0) and a saturating (dut1)
// instance share stimulus; each has its own scoreboard queue of expected
// {value, index} entries pushed on accept and popped on delivery.
module tb_handshake_constant_seq;

    typedef struct packed {
        logic [7:0] v;
        logic [1:0] i;
    } ent_t;

    logic clk;
    logic rst;
    logic ctrl_valid;
    logic idx_clear;
    logic outs_ready;

    logic       cr_w   [2];
    logic [7:0] outs_w [2];
    logic [1:0] oidx_w [2];
    logic       ov_w   [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] tbl [3] = '{8'h0C, 8'hB2, 8'h5A};
    ent_t       sb   [2][$];
    logic [1:0] midx [2];

    handshake_constant_seq #(
        .DATA_WIDTH(8), .NUM_CONSTS(3), .CONST_VALUES(24'h5AB20C), .CYCLIC(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(cr_w[0]),
        .idx_clear(idx_clear), .outs(outs_w[0]), .outs_idx(oidx_w[0]),
        .outs_valid(ov_w[0]), .outs_ready(outs_ready)
    );

    handshake_constant_seq #(
        .DATA_WIDTH(8), .NUM_CONSTS(3), .CONST_VALUES(24'h5AB20C), .CYCLIC(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(cr_w[1]),
        .idx_clear(idx_clear), .outs(outs_w[1]), .outs_idx(oidx_w[1]),
        .outs_valid(ov_w[1]), .outs_ready(outs_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the scoreboard, clock once, then update the model
    task automatic step();
        logic cv, orr, clr, rs;
        logic exp_valid, exp_ready;
        logic push [2];
        logic pop  [2];
        ent_t e;
        cv  = ctrl_valid;
        orr = outs_ready;
        clr = idx_clear;
        rs  = rst;
        for (int d = 0; d < 2; d++) begin
            exp_valid = (sb[d].size() != 0);
            exp_ready = (sb[d].size() < 2);
            chk($sformatf("dut%0d outs_valid", d), 32'(ov_w[d]), 32'(exp_valid));
            chk($sformatf("dut%0d ctrl_ready", d), 32'(cr_w[d]), 32'(exp_ready));
            if (exp_valid) begin
                chk($sformatf("dut%0d outs", d), 32'(outs_w[d]), 32'(sb[d][0].v));
                chk($sformatf("dut%0d outs_idx", d), 32'(oidx_w[d]), 32'(sb[d][0].i));
            end
            push[d] = cv && exp_ready && rs;
            pop[d]  = exp_valid && orr && rs;
        end
        chk("dut0 count<=2", 32'(dut0.count_q <= 2'd2), 32'd1);
        chk("dut1 count<=2", 32'(dut1.count_q <= 2'd2), 32'd1);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rs) begin
                sb[d].delete();
                midx[d] = 2'd0;
            end else begin
                if (pop[d]) void'(sb[d].pop_front());
                if (push[d]) begin
                    e = {tbl[midx[d]], midx[d]};
                    sb[d].push_back(e);
                end
                if (clr) begin
                    midx[d] = 2'd0;
                end else if (push[d]) begin
                    if (midx[d] < 2'd2) midx[d] = midx[d] + 2'd1;
                    else                midx[d] = (d == 0) ? 2'd0 : 2'd2;
                end
            end
        end
        @(negedge clk);
    endtask

    // Two-cycle reset, then confirm the cleared output registers
    task automatic do_reset();
        rst        = 1'b0;
        ctrl_valid = 1'b0;
        idx_clear  = 1'b0;
        outs_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            sb[d].delete();
            midx[d] = 2'd0;
            chk($sformatf("dut%0d reset outs", d), 32'(outs_w[d]), 32'h0);
            chk($sformatf("dut%0d reset outs_idx", d), 32'(oidx_w[d]), 32'h0);
        end
    endtask

    initial begin
        rst        = 1'b0;
        ctrl_valid = 1'b0;
        idx_clear  = 1'b0;
        outs_ready = 1'b0;

        // Reset state
        do_reset();
        step();

        // Streaming: 7 back-to-back tokens, then drain
        ctrl_valid = 1'b1;
        outs_ready = 1'b1;
        repeat (7) step();
        ctrl_valid = 1'b0;
        repeat (2) step();

        // Backpressure: two accepts, then stall, then release
        do_reset();
        ctrl_valid = 1'b1;
        repeat (4) step();
        ctrl_valid = 1'b0;
        outs_ready = 1'b1;
        repeat (3) step();
        // A third accept after release must produce 5A on both instances
        ctrl_valid = 1'b1;
        step();
        ctrl_valid = 1'b0;
        repeat (2) step();

        // idx_clear together with the second push
        do_reset();
        outs_ready = 1'b1;
        ctrl_valid = 1'b1;
        step();
        idx_clear = 1'b1;
        step();
        idx_clear = 1'b0;
        step();
        ctrl_valid = 1'b0;
        repeat (3) step();

        // idx_clear with no push while two entries are buffered
        do_reset();
        ctrl_valid = 1'b1;
        repeat (2) step();
        ctrl_valid = 1'b0;
        idx_clear  = 1'b1;
        step();
        idx_clear  = 1'b0;
        outs_ready = 1'b1;
        repeat (3) step();

        // Reset while the buffer is full
        do_reset();
        ctrl_valid = 1'b1;
        repeat (3) step();
        ctrl_valid = 1'b0;
        rst        = 1'b0;
        step();
        rst = 1'b1;
        step();
        ctrl_valid = 1'b1;
        outs_ready = 1'b1;
        step();
        ctrl_valid = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
